roulette_round_ctrl: RTL
========================

ROULETTE_ROUND_CTRL -- requirements
Module: roulette_round_ctrl

Interface
REQ-001 SPIN_CYCLES, 16, number of SPIN-state cycles per round (range 1..255).
REQ-002 START_BALANCE, 10, balance loaded at reset and on new game (range 1..31).
REQ-003 WIN_THRESHOLD, 20, balance at or above which the game is won (range START_BALANCE+1..31).
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  start/next-round request, active-high, already synchronised; only its rising edge acts.
REQ-007 mode  input  1  bet type: 0 = parity bet, 1 = exact-number bet.
REQ-008 guess  input  5  parity bet: bit0 = 1 even, 0 odd; exact bet: number 0..31.
REQ-009 rand_in  input  5  current value of the external free-running random source.
REQ-010 rng_step  output  1  high on every SPIN cycle; advances the random source.
REQ-011 balance  output  5  current player balance, unsigned.
REQ-012 result  output  5  latched spin number of the last round.
REQ-013 state_code  output  3  current FSM state encoding (REQ-016).
REQ-014 win_led / lose_led  output  1 each  high while last round won / lost, or in WON / LOST.
REQ-015 round_done  output  1  single-cycle pulse in the EVAL cycle.

Function
REQ-016 FSM states and encodings: IDLE=0, SPIN=1, LATCH=2, EVAL=3, SHOW=4, WON=5, LOST=6; code 7 is unused and SHALL go to IDLE next cycle.
REQ-017 start edge = start high this cycle and low the previous cycle; a held start SHALL produce exactly one edge.
REQ-018 IDLE or SHOW + start edge: capture mode and guess into internal registers, clear spin counter, go to SPIN; mode/guess changes afterward SHALL NOT affect the round.
REQ-019 SPIN: rng_step=1, counter increments; after exactly SPIN_CYCLES cycles go to LATCH; start edges ignored.
REQ-020 LATCH: result <= rand_in; go to EVAL next cycle; rng_step=0.
REQ-021 EVAL: parity win when result[0] equals NOT captured guess[0]; exact win when result == captured guess.
REQ-022 Payout: parity win +2, exact win +8, any loss -1; additions saturate at 31; balance never underflows below 0.
REQ-023 EVAL next state: new balance >= WIN_THRESHOLD -> WON; new balance == 0 -> LOST; otherwise SHOW.
REQ-024 win_led/lose_led updated in EVAL, held through SHOW, cleared on entering SPIN; WON forces win_led=1, lose_led=0; LOST the inverse.
REQ-025 WON or LOST + start edge: balance <= START_BALANCE, leds cleared, go to IDLE.
REQ-026 Latency start edge -> round_done = SPIN_CYCLES + 2 cycles.

Reset
REQ-027 reset_n low at a clock edge SHALL, regardless of state: state IDLE, balance START_BALANCE, result 0, rng_step 0, win_led 0, lose_led 0, round_done 0, counter 0, start edge detector history 1 (no edge on the first cycle after reset while start is held).
REQ-028 Reset mid-SPIN or mid-EVAL SHALL discard the round with no balance change.

Configuration
REQ-029 Macro ROULETTE_HOUSE_ZERO_EN defined: result 0 on a parity bet SHALL always lose (-1); exact bet on 0 still wins on 0.
REQ-030 Macro undefined: result 0 treated as even for parity bets.

Verification
REQ-031 Reset, mode=0, guess=1, rand_in=4 at LATCH -> balance 10->12, win_led=1, round_done 18 cycles after start edge, state SHOW.
REQ-032 mode=1, guess=7, rand_in=7 -> balance 10->18; next round same -> 26 >= 20 -> state WON; start edge -> IDLE, balance 10.
REQ-033 Ten consecutive parity losses from 10 -> balance 0, state LOST, lose_led=1; further start edges before reset -> only exit to IDLE.
REQ-034 Balance 30 before exact win -> saturates at 31; guess changed during SPIN -> captured guess used.
REQ-035 Parity guess even, rand_in=0: with ROULETTE_HOUSE_ZERO_EN balance -1, without it +2.
REQ-036 start held high 100 cycles from IDLE -> exactly one round; reset_n low during SPIN -> IDLE, balance unchanged from START_BALANCE.

Source files
------------

// File: rtl/roulette_round_ctrl_if.sv
// Player-side signal bundle for roulette_round_ctrl: request/bet inputs, random
// source handshake, and the round status outputs.
interface roulette_round_ctrl_if;
    logic       start;
    logic       mode;
    logic [4:0] guess;
    logic [4:0] rand_in;
    logic       rng_step;
    logic [4:0] balance;
    logic [4:0] result;
    logic [2:0] state_code;
    logic       win_led;
    logic       lose_led;
    logic       round_done;

    // Environment side: issues requests and supplies the random source
    modport master (
        output start, mode, guess, rand_in,
        input  rng_step, balance, result, state_code, win_led, lose_led, round_done
    );

    // Controller side
    modport slave (
        input  start, mode, guess, rand_in,
        output rng_step, balance, result, state_code, win_led, lose_led, round_done
    );
endinterface

// File: rtl/roulette_round_ctrl.sv
// Roulette round controller: captures a bet, spins an external RNG, latches and scores it.
// Optional macro ROULETTE_HOUSE_ZERO_EN makes a spin of 0 lose every parity bet.
module roulette_round_ctrl #(
    parameter int unsigned SPIN_CYCLES   = 16,
    parameter int unsigned START_BALANCE = 10,
    parameter int unsigned WIN_THRESHOLD = 20
) (
    input  logic                 clock,
    input  logic                 reset_n,
    roulette_round_ctrl_if.slave bus
);

    localparam int unsigned BAL_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = BAL_W + 1;

    localparam logic [BAL_W-1:0] BAL_MAX   = '1;
    localparam logic [BAL_W-1:0] BAL_START = BAL_W'(START_BALANCE);
    localparam logic [BAL_W-1:0] BAL_WIN   = BAL_W'(WIN_THRESHOLD);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [SUM_W-1:0] PAY_PAR   = SUM_W'(2);
    localparam logic [SUM_W-1:0] PAY_EXACT = SUM_W'(8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN  = 3'd1,
        LATCH = 3'd2,
        EVAL  = 3'd3,
        SHOW  = 3'd4,
        WON   = 3'd5,
        LOST  = 3'd6
    } state_t;

    state_t             state;
    logic               start_q;
    logic [CNT_W-1:0]   spin_cnt;
    logic               mode_q;
    logic [BAL_W-1:0]   guess_q;
    logic [BAL_W-1:0]   balance_q;
    logic [BAL_W-1:0]   result_q;
    logic               rng_step_q;
    logic               win_q;
    logic               lose_q;
    logic               done_q;

    logic               start_edge;
    logic               parity_hit;
    logic               exact_hit;
    logic               round_win;
    logic [SUM_W-1:0]   win_sum;
    logic [BAL_W-1:0]   bal_next;

    assign start_edge = bus.start & ~start_q;

    // Score the latched spin against the captured bet and form the new balance
    always_comb begin
        parity_hit = (result_q[0] == ~guess_q[0]);
`ifdef ROULETTE_HOUSE_ZERO_EN
        if (result_q == '0) begin
            parity_hit = 1'b0;
        end
`endif
        exact_hit = (result_q == guess_q);
        round_win = mode_q ? exact_hit : parity_hit;
        win_sum   = {1'b0, balance_q} + (mode_q ? PAY_EXACT : PAY_PAR);
        bal_next  = balance_q;
        if (round_win) begin
            bal_next = win_sum[BAL_W] ? BAL_MAX : win_sum[BAL_W-1:0];
        end else if (balance_q != '0) begin
            bal_next = balance_q - BAL_W'(1);
        end
    end

    // Round sequencing with all status outputs registered
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_q    <= 1'b1;
            spin_cnt   <= '0;
            mode_q     <= 1'b0;
            guess_q    <= '0;
            balance_q  <= BAL_START;
            result_q   <= '0;
            rng_step_q <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= bus.start;
            done_q  <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    if (start_edge) begin
                        mode_q     <= bus.mode;
                        guess_q    <= bus.guess;
                        spin_cnt   <= '0;
                        rng_step_q <= 1'b1;
                        win_q      <= 1'b0;
                        lose_q     <= 1'b0;
                        state      <= SPIN;
                    end
                end
                SPIN: begin
                    spin_cnt <= spin_cnt + CNT_W'(1);
                    if (spin_cnt == SPIN_LAST) begin
                        rng_step_q <= 1'b0;
                        state      <= LATCH;
                    end
                end
                LATCH: begin
                    result_q <= bus.rand_in;
                    done_q   <= 1'b1;
                    state    <= EVAL;
                end
                EVAL: begin
                    balance_q <= bal_next;
                    if (bal_next >= BAL_WIN) begin
                        win_q  <= 1'b1;
                        lose_q <= 1'b0;
                        state  <= WON;
                    end else if (bal_next == '0) begin
                        win_q  <= 1'b0;
                        lose_q <= 1'b1;
                        state  <= LOST;
                    end else begin
                        win_q  <= round_win;
                        lose_q <= ~round_win;
                        state  <= SHOW;
                    end
                end
                WON, LOST: begin
                    // Game over: only a fresh start edge leaves, restarting the purse
                    if (start_edge) begin
                        balance_q <= BAL_START;
                        win_q     <= 1'b0;
                        lose_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rng_step_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.rng_step   = rng_step_q;
    assign bus.balance    = balance_q;
    assign bus.result     = result_q;
    assign bus.state_code = state;
    assign bus.win_led    = win_q;
    assign bus.lose_led   = lose_q;
    assign bus.round_done = done_q;

endmodule
